// File: rtl/song_memory_ctrl_pkg.sv
// Shared types and constants for the song memory sequencer.
// State encoding, slot geometry and default sample rate.
package song_memory_ctrl_pkg;

  localparam int NUM_SLOTS       = 16;
  localparam int SLOT_SEL_W      = 4;
  localparam int SAMPLE_RATE_DEF = 48000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  function automatic int slot_bits(input int addr_w);
    return addr_w - SLOT_SEL_W;
  endfunction

endpackage

// File: rtl/song_memory_ctrl_if.sv
// Sample memory bus: address, write/read strobes, write and read data.
// master = sequencer side, slave = memory side.
interface song_memory_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output mem_addr, mem_we, mem_re, mem_din,
    input  mem_dout
  );

  modport slave (
    input  mem_addr, mem_we, mem_re, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/song_memory_ctrl_length_table.sv
// Per-slot recorded length: 16 entries, one sync write, one comb read.
// Ports: clk, reset (sync clear), we/waddr/wdata, raddr/rdata.
module song_length_table
  import song_memory_ctrl_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [3:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] tab_q [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        tab_q[i] <= '0;
    end else if (we) begin
      tab_q[waddr] <= wdata;
    end
  end

  assign rdata = tab_q[raddr];

endmodule

// File: rtl/song_memory_ctrl.sv
// Sample-rate record/playback sequencer over 16 memory slots.
// Ports: ready/start/pause controls in, mem bus out, play/done/time out.
module song_memory_ctrl
  import song_memory_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 8,
  parameter int RD_LAT      = 2,
  parameter int SAMPLE_RATE = SAMPLE_RATE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              record_mode,
  input  logic [3:0]        song_choice,
  input  logic              start_song,
  input  logic              pause_song,
  input  logic [DATA_W-1:0] rec_sample,
  song_memory_ctrl_if.master mem,
  output logic [DATA_W-1:0] play_sample,
  output logic              play_valid,
  output logic              song_done,
  output logic [9:0]        running_time,
  output logic              active
);

  localparam int SB = slot_bits(ADDR_W);
  localparam int PW = $clog2(SAMPLE_RATE + 1);
  localparam logic [SB:0] FULL = {1'b1, {SB{1'b0}}};

  state_e            state_q, state_d;
  logic [3:0]        slot_q, slot_d;
  logic [SB:0]       off_q, off_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [9:0]        rt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              done_d;
  logic              len_we;
  logic [SB:0]       len_rd;
  logic              acc, fin;
  logic [RD_LAT-1:0] vld_q;

  song_length_table #(.W(SB + 1)) u_len (
    .clk   (clk),
    .reset (reset),
    .we    (len_we),
    .waddr (slot_q),
    .wdata (off_q + (SB + 1)'(1)),
    .raddr (slot_q),
    .rdata (len_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    off_d   = off_q;
    presc_d = presc_q;
    rt_d    = running_time;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    done_d  = 1'b0;
    len_we  = 1'b0;
    fin     = 1'b0;
    acc     = ready & ~pause_song & ~start_song
            & (state_q != ST_IDLE);
    unique case (1'b1)
      (state_q == ST_REC):  fin = (off_q == FULL);
      (state_q == ST_PLAY): fin = (off_q == len_rd);
      default:              fin = 1'b0;
    endcase
    if (start_song) begin
      state_d = record_mode ? ST_REC : ST_PLAY;
      slot_d  = song_choice;
      off_d   = '0;
      presc_d = '0;
      rt_d    = '0;
    end else if (acc) begin
      if (fin) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        addr_d = {slot_q, off_q[SB-1:0]};
        off_d  = off_q + (SB + 1)'(1);
        if (state_q == ST_REC) begin
          we_d   = 1'b1;
          din_d  = rec_sample;
          len_we = 1'b1;
        end else begin
          re_d = 1'b1;
        end
        // one second elapses every SAMPLE_RATE accepted strobes
        if (presc_q == PW'(SAMPLE_RATE - 1)) begin
          presc_d = '0;
          if (running_time != 10'd1023)
            rt_d = running_time + 10'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q       <= '0;
      off_q        <= '0;
      presc_q      <= '0;
      running_time <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      song_done    <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      off_q        <= off_d;
      presc_q      <= presc_d;
      running_time <= rt_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      we_q         <= we_d;
      re_q         <= re_d;
      song_done    <= done_d;
    end
  end

  // read-valid pipeline is state-independent so issued reads always land
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      play_valid  <= 1'b0;
      play_sample <= '0;
    end else begin
      vld_q[0] <= re_q;
      for (int i = 1; i < RD_LAT; i++)
        vld_q[i] <= vld_q[i-1];
      play_valid <= vld_q[RD_LAT-1];
      if (vld_q[RD_LAT-1])
        play_sample <= mem.mem_dout;
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_we   = we_q;
  assign mem.mem_re   = re_q;
  assign mem.mem_din  = din_q;
  assign active       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_song_memory_ctrl.sv
// Directed bench for song_memory_ctrl with a 2-cycle-latency memory.
// ADDR_W=8, DATA_W=8, RD_LAT=2, SAMPLE_RATE=4.
module tb_song_memory_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic       record_mode;
  logic [3:0] song_choice;
  logic       start_song;
  logic       pause_song;
  logic [7:0] rec_sample;
  logic [7:0] play_sample;
  logic       play_valid;
  logic       song_done;
  logic [9:0] running_time;
  logic       active;

  int total = 0;
  int bad   = 0;

  logic       s_we, s_re, s_done, s_done2, s_act, s_pv;
  logic [7:0] s_addr, s_din, s_ps;
  logic [9:0] s_rt;

  logic [7:0] mem_arr [256];
  logic [7:0] rd_pipe [2];

  always #5 clk = ~clk;

  song_memory_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  song_memory_ctrl #(
    .ADDR_W(8), .DATA_W(8), .RD_LAT(2), .SAMPLE_RATE(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .record_mode  (record_mode),
    .song_choice  (song_choice),
    .start_song   (start_song),
    .pause_song   (pause_song),
    .rec_sample   (rec_sample),
    .mem          (bus),
    .play_sample  (play_sample),
    .play_valid   (play_valid),
    .song_done    (song_done),
    .running_time (running_time),
    .active       (active)
  );

  always @(posedge clk) begin
    if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_din;
    rd_pipe[0] <= mem_arr[bus.mem_addr];
    rd_pipe[1] <= rd_pipe[0];
  end
  assign bus.mem_dout = rd_pipe[1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic rm, input logic [3:0] ch,
                       input logic rdy);
    record_mode = rm;
    song_choice = ch;
    start_song  = 1'b1;
    ready       = rdy;
    tick;
    start_song  = 1'b0;
    ready       = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] smp);
    rec_sample = smp;
    ready = 1'b1;
    tick;
    ready  = 1'b0;
    s_we   = bus.mem_we;
    s_re   = bus.mem_re;
    s_addr = bus.mem_addr;
    s_din  = bus.mem_din;
    s_done = song_done;
    s_act  = active;
    s_rt   = running_time;
    tick;
    s_done2 = song_done;
    tick;
    tick;
    s_pv = play_valid;
    s_ps = play_sample;
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; record_mode = 1'b0;
    song_choice = '0; start_song = 1'b0; pause_song = 1'b0;
    rec_sample = '0;
    tick; tick;
    reset = 1'b0;
    chk("rst_we", bus.mem_we, 0);
    chk("rst_re", bus.mem_re, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_done", song_done, 0);
    chk("rst_active", active, 0);
    chk("rst_time", running_time, 0);
    chk("rst_pv", play_valid, 0);

    // record 5 samples into slot 3
    start(1'b1, 4'd3, 1'b0);
    chk("rec3_active", active, 1);
    for (int i = 0; i < 5; i++) begin
      strobe(8'h11 + 8'(i));
      chk("rec3_we", s_we, 1);
      chk("rec3_addr", s_addr, 8'h30 + 8'(i));
      chk("rec3_din", s_din, 8'h11 + 8'(i));
    end
    chk("rec3_time", s_rt, 1);

    // play slot 3 back
    start(1'b0, 4'd3, 1'b0);
    chk("play3_time_clr", running_time, 0);
    for (int i = 0; i < 5; i++) begin
      strobe(8'h00);
      chk("play3_re", s_re, 1);
      chk("play3_addr", s_addr, 8'h30 + 8'(i));
      chk("play3_pv", s_pv, 1);
      chk("play3_data", s_ps, 8'h11 + 8'(i));
    end
    strobe(8'h00);
    chk("play3_done", s_done, 1);
    chk("play3_end_re", s_re, 0);
    chk("play3_end_act", s_act, 0);
    chk("play3_done_pulse", s_done2, 0);

    // fill slot 0 completely
    start(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      strobe(8'hA0 + 8'(i));
      chk("full_we", s_we, 1);
      chk("full_addr", s_addr, 8'(i));
    end
    strobe(8'hFF);
    chk("full_done", s_done, 1);
    chk("full_no_we", s_we, 0);
    chk("full_act", s_act, 0);

    // replay slot 0: 16 reads, then end
    start(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      strobe(8'h00);
      chk("full_play_addr", s_addr, 8'(i));
      chk("full_play_data", s_ps, 8'hA0 + 8'(i));
    end
    strobe(8'h00);
    chk("full_play_done", s_done, 1);
    chk("full_play_no_re", s_re, 0);

    // empty slot 9
    start(1'b0, 4'd9, 1'b0);
    strobe(8'h00);
    chk("empty_done", s_done, 1);
    chk("empty_no_re", s_re, 0);

    // strobe in IDLE is dropped
    strobe(8'h77);
    chk("idle_we", s_we, 0);
    chk("idle_re", s_re, 0);
    chk("idle_done", s_done, 0);

    // pause freezes offset and time
    start(1'b1, 4'd5, 1'b0);
    strobe(8'h01);
    chk("pause_a0", s_addr, 8'h50);
    strobe(8'h02);
    chk("pause_a1", s_addr, 8'h51);
    pause_song = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe(8'h03);
      chk("paused_we", s_we, 0);
    end
    pause_song = 1'b0;
    strobe(8'h04);
    chk("pause_resume_addr", s_addr, 8'h52);
    chk("pause_time", s_rt, 0);

    // ready coincident with start is ignored
    start(1'b1, 4'd6, 1'b1);
    chk("coinc_no_we", bus.mem_we, 0);
    strobe(8'h60);
    chk("coinc_addr", s_addr, 8'h60);
    for (int i = 2; i <= 9; i++) begin
      strobe(8'h60 + 8'(i));
      if (i == 3) chk("time_3", s_rt, 0);
      if (i == 4) chk("time_4", s_rt, 1);
    end
    chk("time_9", s_rt, 2);
    chk("time_9_addr", s_addr, 8'h68);

    // reset mid-record
    reset = 1'b1;
    ready = 1'b1;
    tick;
    reset = 1'b0;
    ready = 1'b0;
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_addr", bus.mem_addr, 0);
    chk("mid_rst_din", bus.mem_din, 0);
    chk("mid_rst_act", active, 0);
    chk("mid_rst_time", running_time, 0);
    chk("mid_rst_ps", play_sample, 0);
    start(1'b0, 4'd6, 1'b0);
    strobe(8'h00);
    chk("post_rst_done", s_done, 1);
    chk("post_rst_no_re", s_re, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
